// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock sequencer: state encodings and sizing helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lock_pkg;

    localparam int STATE_W    = 3;
    localparam int DEF_CODE_W = 7;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE           = 3'b000,
        ST_SET_AWAITING   = 3'b001,
        ST_OPENED         = 3'b010,
        ST_ALARM          = 3'b011,
        ST_INPUT_PASSWORD = 3'b100
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that stops at zero and flags when it is there.
// Latency: load/decrement visible the cycle after load_i/en_i.
// Backpressure: none; load_i has priority over en_i.
module lock_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Count register: load wins, otherwise decrement while enabled and not already at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Combination-lock controller: password entry/compare, open/relock, password change, alarm lockout.
// Latency: a button event in cycle N is reflected on state and all outputs in cycle N+1.
// Backpressure: none; events arriving in states that do not use them are dropped.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int                 CODE_W         = DEF_CODE_W,
    parameter int                 MAX_TRIES      = 3,
    parameter int                 LOCKOUT_CYCLES = 1000,
    parameter int                 OPEN_TIMEOUT   = 5000,
    parameter int                 BLINK_HALF     = 100,
    parameter logic [CODE_W-1:0]  RESET_CODE     = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           set_pulse,
    input  logic                           enter_pulse,
    input  logic [CODE_W-1:0]              code_in,
    output logic [STATE_W-1:0]             state,
    output logic                           unlocked,
    output logic                           alarm,
    output logic                           blink,
    output logic                           pw_updated,
    output logic [$clog2(MAX_TRIES+1)-1:0] fail_count
);

    localparam int FW  = $clog2(MAX_TRIES + 1);
    localparam int FW1 = FW + 1;
    localparam int TW  = $clog2(max_int(LOCKOUT_CYCLES, OPEN_TIMEOUT) + 1);
    localparam int BW  = $clog2(BLINK_HALF + 1);

    // Timers are loaded with N-1 and the exit is taken on the zero flag, so the
    // state dwells exactly N cycles counting its entry cycle.
    localparam logic [TW-1:0]  OPEN_LD  = TW'(OPEN_TIMEOUT - 1);
    localparam logic [TW-1:0]  LOCK_LD  = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [BW-1:0]  BLINK_LD = BW'(BLINK_HALF - 1);
    localparam logic [FW:0]    MAX_EXT  = FW1'(MAX_TRIES);

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   pw_q, pw_d;
    logic [FW-1:0]       fail_q, fail_d;
    logic [FW:0]         fail_inc;
    logic                blink_q, blink_d;
    logic                unlocked_q, alarm_q, pw_upd_q, pw_upd_d;

    logic                tmr_load, tmr_en, tmr_zero;
    logic [TW-1:0]       tmr_val;
    logic                blk_load, blk_en, blk_zero;

    // Shared open/lockout timer; OPENED and ALARM never overlap.
    lock_timer #(.W(TW)) u_main_tmr (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    // Blink half-period timer, reloaded on every toggle while in ALARM.
    lock_timer #(.W(BW)) u_blink_tmr (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (blk_load),
        .load_val_i (BLINK_LD),
        .en_i       (blk_en),
        .zero_o     (blk_zero)
    );

    assign tmr_en   = (state_q == ST_OPENED) || (state_q == ST_ALARM);
    assign blk_en   = (state_q == ST_ALARM);
    assign fail_inc = {1'b0, fail_q} + FW1'(1);

    // Next-state, password, fail counter and timer-load decisions; enter has priority over set.
    always_comb begin
        state_d  = state_q;
        pw_d     = pw_q;
        fail_d   = fail_q;
        blink_d  = blink_q;
        pw_upd_d = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = OPEN_LD;
        blk_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enter_pulse) state_d = ST_INPUT_PASSWORD;
            end
            ST_INPUT_PASSWORD: begin
                if (enter_pulse) begin
                    if (code_in == pw_q) begin
                        state_d  = ST_OPENED;
                        fail_d   = '0;
                        tmr_load = 1'b1;
                        tmr_val  = OPEN_LD;
                    end else if (fail_inc < MAX_EXT) begin
                        state_d  = ST_IDLE;
                        fail_d   = fail_inc[FW-1:0];
                    end else begin
                        state_d  = ST_ALARM;
                        fail_d   = MAX_EXT[FW-1:0];
                        tmr_load = 1'b1;
                        tmr_val  = LOCK_LD;
                        blk_load = 1'b1;
                        blink_d  = 1'b1;
                    end
                end
            end
            ST_OPENED: begin
                if (enter_pulse)    state_d = ST_IDLE;
                else if (set_pulse) state_d = ST_SET_AWAITING;
                else if (tmr_zero)  state_d = ST_IDLE;
            end
            ST_SET_AWAITING: begin
                if (enter_pulse) begin
                    state_d = ST_IDLE;
                end else if (set_pulse) begin
                    state_d  = ST_IDLE;
                    pw_d     = code_in;
                    pw_upd_d = 1'b1;
                end
            end
            ST_ALARM: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                    blink_d = 1'b0;
                end else if (blk_zero) begin
                    blink_d  = ~blink_q;
                    blk_load = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                blink_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; status flags follow the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pw_q       <= RESET_CODE;
            fail_q     <= '0;
            blink_q    <= 1'b0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
            pw_upd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pw_q       <= pw_d;
            fail_q     <= fail_d;
            blink_q    <= blink_d;
            unlocked_q <= (state_d == ST_OPENED);
            alarm_q    <= (state_d == ST_ALARM);
            pw_upd_q   <= pw_upd_d;
        end
    end

    assign state      = state_q;
    assign unlocked   = unlocked_q;
    assign alarm      = alarm_q;
    assign blink      = blink_q;
    assign pw_updated = pw_upd_q;
    assign fail_count = fail_q;

endmodule
